// File: rtl/release_writeback_unit.sv
// -----------------------------------------------------------------------------
// release_writeback_unit
//   Turns an arbitrated client release into memory write traffic.
//   Releases carrying data (r_type 0..2) become one 8-beat write burst
//   (AW, 8 x W, B).
//   Voluntary releases are acknowledged to the client with a grant once the
//   write response returns.
//   Dataless voluntary releases go straight to the grant.
//   Dataless non-voluntary releases are consumed with no traffic at all.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   io_in_*                         release beat input (valid/ready)
//   io_aw_*                         write-address channel, addr={block,6'h0}, len=7
//   io_w_*                          write-data channel, w_last on the 8th beat
//   io_b_*                          write-response channel, nonzero resp = error
//   io_grant_*                      release acknowledge to the originating client
//   io_error                        sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module release_writeback_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic [1:0]  io_in_bits_header_src,
  input  logic [2:0]  io_in_bits_payload_addr_beat,
  input  logic [25:0] io_in_bits_payload_addr_block,
  input  logic        io_in_bits_payload_client_xact_id,
  input  logic        io_in_bits_payload_voluntary,
  input  logic [2:0]  io_in_bits_payload_r_type,
  input  logic [63:0] io_in_bits_payload_data,
  output logic        io_aw_valid,
  input  logic        io_aw_ready,
  output logic [31:0] io_aw_addr,
  output logic [7:0]  io_aw_len,
  output logic        io_w_valid,
  input  logic        io_w_ready,
  output logic [63:0] io_w_data,
  output logic        io_w_last,
  input  logic        io_b_valid,
  output logic        io_b_ready,
  input  logic [1:0]  io_b_resp,
  output logic        io_grant_valid,
  input  logic        io_grant_ready,
  output logic [1:0]  io_grant_dst,
  output logic        io_grant_client_xact_id,
  output logic        io_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AW    = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GRANT = 3'd4
  } state_t;

  state_t      state_r;
  logic        hold_valid_r;
  logic [63:0] hold_data_r;
  logic [1:0]  src_r;
  logic        xact_r;
  logic        vol_r;
  logic [25:0] block_r;
  logic [2:0]  cnt_r;       // W beats sent in the current burst
  logic [3:0]  acc_cnt_r;   // data beats accepted in the current burst (0..8)
  logic        error_r;
  logic        aw_valid_r;
  logic        b_ready_r;
  logic        grant_valid_r;

  logic        in_ready_s;
  logic        w_valid_s;
  logic        in_fire_s;
  logic        w_fire_s;
  logic        has_data_s;

  // Input-ready decode: IDLE always accepts (once out of reset); DATA accepts
  // when the hold slot is empty or draining this cycle, until 8 beats are in.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = reset;
      ST_DATA: in_ready_s = (!hold_valid_r || (w_valid_s && io_w_ready)) && !acc_cnt_r[3];
      default: in_ready_s = 1'b0;
    endcase
  end

  assign w_valid_s  = (state_r == ST_DATA) && hold_valid_r;
  assign in_fire_s  = io_in_valid && in_ready_s;
  assign w_fire_s   = w_valid_s && io_w_ready;
  assign has_data_s = (io_in_bits_payload_r_type <= 3'd2);

  // Transaction FSM with hold register, beat counters and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      hold_valid_r  <= 1'b0;
      hold_data_r   <= 64'h0;
      src_r         <= 2'd0;
      xact_r        <= 1'b0;
      vol_r         <= 1'b0;
      block_r       <= 26'h0;
      cnt_r         <= 3'd0;
      acc_cnt_r     <= 4'd0;
      error_r       <= 1'b0;
      aw_valid_r    <= 1'b0;
      b_ready_r     <= 1'b0;
      grant_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s) begin
            src_r  <= io_in_bits_header_src;
            xact_r <= io_in_bits_payload_client_xact_id;
            vol_r  <= io_in_bits_payload_voluntary;
            if (has_data_s) begin
              block_r      <= io_in_bits_payload_addr_block;
              hold_data_r  <= io_in_bits_payload_data;
              hold_valid_r <= 1'b1;
              acc_cnt_r    <= 4'd1;
              cnt_r        <= 3'd0;
              if (io_in_bits_payload_addr_beat != 3'd0) begin
                error_r <= 1'b1;
              end
              aw_valid_r <= 1'b1;
              state_r    <= ST_AW;
            end else if (io_in_bits_payload_voluntary) begin
              grant_valid_r <= 1'b1;
              state_r       <= ST_GRANT;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_AW: begin
          if (io_aw_ready) begin
            aw_valid_r <= 1'b0;
            cnt_r      <= 3'd0;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fire_s) begin
            cnt_r <= cnt_r + 3'd1;
          end
          // A new beat refills the slot even while the old one drains.
          if (in_fire_s) begin
            hold_data_r  <= io_in_bits_payload_data;
            hold_valid_r <= 1'b1;
            acc_cnt_r    <= acc_cnt_r + 4'd1;
            if ((io_in_bits_payload_addr_beat != acc_cnt_r[2:0]) || !has_data_s) begin
              error_r <= 1'b1;
            end
          end else if (w_fire_s) begin
            hold_valid_r <= 1'b0;
          end
          if (w_fire_s && (cnt_r == 3'd7)) begin
            b_ready_r <= 1'b1;
            state_r   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_b_valid) begin
            b_ready_r <= 1'b0;
            if (io_b_resp != 2'b00) begin
              error_r <= 1'b1;
            end
            if (vol_r) begin
              grant_valid_r <= 1'b1;
              state_r       <= ST_GRANT;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_GRANT: begin
          if (io_grant_ready) begin
            grant_valid_r <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          hold_valid_r  <= 1'b0;
          aw_valid_r    <= 1'b0;
          b_ready_r     <= 1'b0;
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign io_in_ready             = in_ready_s;
  assign io_aw_valid             = aw_valid_r;
  assign io_aw_addr              = {block_r, 6'h00};
  assign io_aw_len               = 8'h07;
  assign io_w_valid              = w_valid_s;
  assign io_w_data               = hold_data_r;
  assign io_w_last               = (state_r == ST_DATA) && (cnt_r == 3'd7);
  assign io_b_ready              = b_ready_r;
  assign io_grant_valid          = grant_valid_r;
  assign io_grant_dst            = src_r;
  assign io_grant_client_xact_id = xact_r;
  assign io_error                = error_r;

endmodule

// File: tb/tb_release_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_release_writeback_unit
//   Directed bench for release_writeback_unit. Inputs change 1 ns after the
//   rising edge; a negedge monitor logs every channel fire.
// -----------------------------------------------------------------------------
module tb_release_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_ready;
  logic        io_in_valid;
  logic [1:0]  io_in_bits_header_src;
  logic [2:0]  io_in_bits_payload_addr_beat;
  logic [25:0] io_in_bits_payload_addr_block;
  logic        io_in_bits_payload_client_xact_id;
  logic        io_in_bits_payload_voluntary;
  logic [2:0]  io_in_bits_payload_r_type;
  logic [63:0] io_in_bits_payload_data;
  logic        io_aw_valid;
  logic        io_aw_ready;
  logic [31:0] io_aw_addr;
  logic [7:0]  io_aw_len;
  logic        io_w_valid;
  logic        io_w_ready;
  logic [63:0] io_w_data;
  logic        io_w_last;
  logic        io_b_valid;
  logic        io_b_ready;
  logic [1:0]  io_b_resp;
  logic        io_grant_valid;
  logic        io_grant_ready;
  logic [1:0]  io_grant_dst;
  logic        io_grant_client_xact_id;
  logic        io_error;

  int errors = 0;
  int checks = 0;
  logic w_toggle = 1'b0;

  // monitor log
  int          aw_n = 0, w_n = 0, b_n = 0, grant_n = 0;
  logic [31:0] last_aw_addr;
  logic [7:0]  last_aw_len;
  logic [1:0]  last_dst;
  logic        last_xact;
  logic [63:0] w_log [0:255];
  logic        wl_log [0:255];

  release_writeback_unit dut (
    .clk(clk), .reset(reset),
    .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
    .io_in_bits_header_src(io_in_bits_header_src),
    .io_in_bits_payload_addr_beat(io_in_bits_payload_addr_beat),
    .io_in_bits_payload_addr_block(io_in_bits_payload_addr_block),
    .io_in_bits_payload_client_xact_id(io_in_bits_payload_client_xact_id),
    .io_in_bits_payload_voluntary(io_in_bits_payload_voluntary),
    .io_in_bits_payload_r_type(io_in_bits_payload_r_type),
    .io_in_bits_payload_data(io_in_bits_payload_data),
    .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready),
    .io_aw_addr(io_aw_addr), .io_aw_len(io_aw_len),
    .io_w_valid(io_w_valid), .io_w_ready(io_w_ready),
    .io_w_data(io_w_data), .io_w_last(io_w_last),
    .io_b_valid(io_b_valid), .io_b_ready(io_b_ready), .io_b_resp(io_b_resp),
    .io_grant_valid(io_grant_valid), .io_grant_ready(io_grant_ready),
    .io_grant_dst(io_grant_dst), .io_grant_client_xact_id(io_grant_client_xact_id),
    .io_error(io_error)
  );

  always #5 clk = ~clk;

  // W-ready driver: constant 1 or toggling every cycle.
  initial begin
    io_w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (w_toggle) io_w_ready = ~io_w_ready;
      else          io_w_ready = 1'b1;
    end
  end

  // Fire monitor, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (io_aw_valid && io_aw_ready) begin
      aw_n <= aw_n + 1;
      last_aw_addr <= io_aw_addr;
      last_aw_len  <= io_aw_len;
    end
    if (io_w_valid && io_w_ready) begin
      w_log[w_n[7:0]]  <= io_w_data;
      wl_log[w_n[7:0]] <= io_w_last;
      w_n <= w_n + 1;
    end
    if (io_b_valid && io_b_ready) b_n <= b_n + 1;
    if (io_grant_valid && io_grant_ready) begin
      grant_n   <= grant_n + 1;
      last_dst  <= io_grant_dst;
      last_xact <= io_grant_client_xact_id;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_hdr(input logic [1:0] src, input logic xact, input logic vol,
                         input logic [25:0] blk);
    io_in_bits_header_src             = src;
    io_in_bits_payload_client_xact_id = xact;
    io_in_bits_payload_voluntary      = vol;
    io_in_bits_payload_addr_block     = blk;
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after the fire edge.
  task automatic put_beat(input logic [2:0] beat, input logic [2:0] rt, input logic [63:0] d);
    bit ok = 1'b0;
    io_in_bits_payload_addr_beat = beat;
    io_in_bits_payload_r_type    = rt;
    io_in_bits_payload_data      = d;
    io_in_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (io_in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    io_in_valid = 1'b0;
    if (!ok) check_val("put_timeout", 64'd0, 64'd1);
  endtask

  // Wait (bounded) for the unit to accept again, i.e. back in IDLE.
  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (io_in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) check_val(tag, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [7:0] t, input int i);
    return {8'hC0, t, 16'h0, 32'(i)} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  int b0, w0, g0, a0;

  initial begin
    reset = 1'b0;
    io_in_valid = 1'b0;
    set_hdr(2'd0, 1'b0, 1'b0, 26'h0);
    io_in_bits_payload_addr_beat = 3'd0;
    io_in_bits_payload_r_type    = 3'd0;
    io_in_bits_payload_data      = 64'h0;
    io_aw_ready = 1'b1;
    io_b_valid = 1'b1;
    io_b_resp = 2'b00;
    io_grant_ready = 1'b1;

    // ---- reset state ----
    #2;
    check_val("rst_in_ready", io_in_ready, 1'b0);
    check_val("rst_aw_valid", io_aw_valid, 1'b0);
    check_val("rst_w_valid", io_w_valid, 1'b0);
    check_val("rst_b_ready", io_b_ready, 1'b0);
    check_val("rst_grant_valid", io_grant_valid, 1'b0);
    check_val("rst_error", io_error, 1'b0);
    do_reset();
    check_val("post_rst_in_ready", io_in_ready, 1'b1);

    // ---- T1: voluntary r_type 0, block 1, all ready ----
    a0 = aw_n; w0 = w_n; b0 = b_n; g0 = grant_n;
    set_hdr(2'd2, 1'b1, 1'b1, 26'h1);
    put_beat(3'd0, 3'd0, pat(8'h01, 0));
    check_val("t1_aw_valid", io_aw_valid, 1'b1);
    check_val("t1_in_ready_aw", io_in_ready, 1'b0);
    for (int i = 1; i < 8; i++) put_beat(3'(i), 3'd0, pat(8'h01, i));
    wait_idle("t1_idle_timeout");
    check_val("t1_aw_n", aw_n - a0, 1);
    check_val("t1_aw_addr", last_aw_addr, 32'h40);
    check_val("t1_aw_len", last_aw_len, 8'h07);
    check_val("t1_w_n", w_n - w0, 8);
    for (int i = 0; i < 8; i++) begin
      check_val("t1_w_data", w_log[w0 + i], pat(8'h01, i));
      check_val("t1_w_last", wl_log[w0 + i], (i == 7) ? 1'b1 : 1'b0);
    end
    check_val("t1_b_n", b_n - b0, 1);
    check_val("t1_grant_n", grant_n - g0, 1);
    check_val("t1_grant_dst", last_dst, 2'd2);
    check_val("t1_grant_xact", last_xact, 1'b1);
    check_val("t1_error", io_error, 1'b0);

    // ---- T2: non-voluntary r_type 1, w_ready toggling ----
    a0 = aw_n; w0 = w_n; b0 = b_n; g0 = grant_n;
    w_toggle = 1'b1;
    set_hdr(2'd1, 1'b0, 1'b0, 26'h2AB_CDEF);
    for (int i = 0; i < 8; i++) put_beat(3'(i), 3'd1, pat(8'h02, i));
    wait_idle("t2_idle_timeout");
    w_toggle = 1'b0;
    check_val("t2_aw_addr", last_aw_addr, 32'hAAF3_7BC0);
    check_val("t2_w_n", w_n - w0, 8);
    for (int i = 0; i < 8; i++) check_val("t2_w_data", w_log[w0 + i], pat(8'h02, i));
    check_val("t2_b_n", b_n - b0, 1);
    check_val("t2_grant_n", grant_n - g0, 0);
    check_val("t2_error", io_error, 1'b0);

    // ---- T3: dataless voluntary, grant held off 3 cycles ----
    a0 = aw_n; g0 = grant_n;
    io_grant_ready = 1'b0;
    set_hdr(2'd3, 1'b1, 1'b1, 26'h5);
    put_beat(3'd0, 3'd3, 64'h0);
    for (int i = 0; i < 3; i++) begin
      check_val("t3_grant_valid", io_grant_valid, 1'b1);
      check_val("t3_grant_dst", io_grant_dst, 2'd3);
      check_val("t3_grant_xact", io_grant_client_xact_id, 1'b1);
      check_val("t3_aw_valid", io_aw_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    io_grant_ready = 1'b1;
    wait_idle("t3_idle_timeout");
    check_val("t3_grant_n", grant_n - g0, 1);
    check_val("t3_aw_n", aw_n - a0, 0);

    // ---- T3b: dataless non-voluntary is dropped ----
    a0 = aw_n; g0 = grant_n;
    set_hdr(2'd1, 1'b0, 1'b0, 26'h6);
    put_beat(3'd0, 3'd5, 64'h0);
    check_val("t3b_in_ready", io_in_ready, 1'b1);
    check_val("t3b_grant_valid", io_grant_valid, 1'b0);
    check_val("t3b_aw_valid", io_aw_valid, 1'b0);

    // ---- T4: beat order 0,1,3,... sets sticky error ----
    w0 = w_n;
    set_hdr(2'd0, 1'b0, 1'b0, 26'h10);
    for (int i = 0; i < 8; i++) begin
      put_beat(3'((i < 2) ? i : i + 1), 3'd0, pat(8'h04, i));
      if (i == 1) check_val("t4_error_pre", io_error, 1'b0);
      if (i == 2) check_val("t4_error_set", io_error, 1'b1);
    end
    wait_idle("t4_idle_timeout");
    check_val("t4_w_n", w_n - w0, 8);
    check_val("t4_w_data2", w_log[w0 + 2], pat(8'h04, 2));
    check_val("t4_error_sticky", io_error, 1'b1);
    do_reset();
    check_val("t4_error_cleared", io_error, 1'b0);

    // ---- T5a: error response ----
    io_b_resp = 2'b10;
    set_hdr(2'd1, 1'b1, 1'b0, 26'h20);
    for (int i = 0; i < 8; i++) put_beat(3'(i), 3'd2, pat(8'h05, i));
    wait_idle("t5a_idle_timeout");
    check_val("t5a_error", io_error, 1'b1);
    io_b_resp = 2'b00;

    // ---- T5b: reset pulse mid-DATA ----
    set_hdr(2'd2, 1'b1, 1'b1, 26'h30);
    for (int i = 0; i < 3; i++) put_beat(3'(i), 3'd0, pat(8'h06, i));
    reset = 1'b0;
    #1;
    check_val("t5b_rst_in_ready", io_in_ready, 1'b0);
    check_val("t5b_rst_w_valid", io_w_valid, 1'b0);
    check_val("t5b_rst_error", io_error, 1'b0);
    w0 = w_n; b0 = b_n; g0 = grant_n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("t5b_idle_in_ready", io_in_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check_val("t5b_no_w", w_n - w0, 0);
    check_val("t5b_no_b", b_n - b0, 0);
    check_val("t5b_no_grant", grant_n - g0, 0);
    check_val("t5b_aw_valid", io_aw_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
